// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared constants and state encoding for the DDS rate controller
//
// Purpose: defaults for counter width and divide ratio, smallest legal ratio,
//          and the controller state encoding used by dds_rate_controller.
// Ports:   none (package)

package dds_pkg;

    localparam int CNT_W       = 16;
    localparam int DIV_DEFAULT = 100;
    localparam int DIV_MIN     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

endpackage

// File: rtl/dds_rate_controller_if.sv
// rtl/dds_rate_controller_if.sv - ratio configuration handshake bundle
//
// Purpose: groups the divide-ratio request handshake between the config/UI
//          logic (master) and the rate controller (slave).
// Signals: cfg_div   requested divide ratio        (master -> slave)
//          cfg_valid cfg_div valid                 (master -> slave)
//          cfg_ready controller can accept cfg_div (slave -> master)
//          cfg_err   1-cycle pulse, request < minimum ratio was discarded

interface dds_rate_controller_if #(
    parameter int CNT_W = dds_pkg::CNT_W
) ();

    logic [CNT_W-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_div,
        output cfg_valid,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_div,
        input  cfg_valid,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/dds_rate_controller.sv
// rtl/dds_rate_controller.sv - programmable sample-rate scheduler for the DDS datapath
//
// Purpose: divides clk_100MHz by a runtime ratio, producing a 1-cycle sample
//          strobe (tick) and a square wave (clk_div). New ratios arrive over a
//          valid/ready handshake and take effect only at period boundaries so
//          downstream logic never sees a shortened sample period.
// Ports:   clk_100MHz  system clock
//          rst_n       asynchronous active-low reset
//          enable      run request (level)
//          cfg         ratio handshake (slave side of dds_rate_controller_if)
//          tick        1-cycle strobe, once per div_active cycles
//          clk_div     low floor(div/2) cycles, high ceil(div/2) cycles
//          div_active  ratio currently in force
//          busy        1 while running or holding a pending ratio
//          sample_cnt  tick counter, present only with DDS_RATE_SAMPLE_CNT_EN
// Options: DDS_RATE_SAMPLE_CNT_EN adds the 32-bit sample_cnt output.
// clk_div is intended for the DAC pin only; internal consumers use tick as a
// clock enable.

module dds_rate_controller
    import dds_pkg::state_t;
    import dds_pkg::ST_IDLE;
    import dds_pkg::ST_RUN;
    import dds_pkg::ST_PEND;
#(
    parameter int CNT_W       = dds_pkg::CNT_W,
    parameter int DIV_DEFAULT = dds_pkg::DIV_DEFAULT,
    parameter int DIV_MIN     = dds_pkg::DIV_MIN
) (
    input  logic                   clk_100MHz,
    input  logic                   rst_n,
    input  logic                   enable,
    dds_rate_controller_if.slave   cfg,
    output logic                   tick,
    output logic                   clk_div,
    output logic [CNT_W-1:0]       div_active,
    output logic                   busy
`ifdef DDS_RATE_SAMPLE_CNT_EN
    ,
    output logic [31:0]            sample_cnt
`endif
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_active;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_tick;
    logic             r_clk_div;
    logic             r_cfg_err;

    logic             w_xfer;
    logic             w_legal;
    logic             w_xfer_ok;
    logic             w_last;
    logic [CNT_W-1:0] w_half;

    assign w_xfer    = cfg.cfg_valid && (r_state != ST_PEND);
    assign w_legal   = cfg.cfg_div >= CNT_W'(DIV_MIN);
    assign w_xfer_ok = w_xfer && w_legal;
    assign w_last    = (r_cnt == r_div_active - CNT_W'(1));
    assign w_half    = r_div_active >> 1;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_div_active <= CNT_W'(DIV_DEFAULT);
            r_div_pend   <= CNT_W'(DIV_DEFAULT);
            r_tick       <= 1'b0;
            r_clk_div    <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            // Illegal requests are still consumed; they only raise the error pulse.
            r_cfg_err <= w_xfer && !w_legal;

            case (r_state)
                ST_IDLE: begin
                    r_cnt     <= '0;
                    r_tick    <= 1'b0;
                    r_clk_div <= 1'b0;
                    if (w_xfer_ok) begin
                        r_div_active <= cfg.cfg_div;
                    end
                    if (enable) begin
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN, ST_PEND: begin
                    if (!enable) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        r_tick    <= 1'b0;
                        r_clk_div <= 1'b0;
                        // Stopping is itself a period boundary: commit whatever is waiting.
                        if (r_state == ST_PEND) begin
                            r_div_active <= r_div_pend;
                        end else if (w_xfer_ok) begin
                            r_div_active <= cfg.cfg_div;
                        end
                    end else begin
                        r_cnt     <= w_last ? '0 : r_cnt + CNT_W'(1);
                        r_tick    <= w_last;
                        r_clk_div <= (r_cnt >= w_half);
                        if (r_state == ST_PEND) begin
                            if (w_last) begin
                                r_div_active <= r_div_pend;
                                r_state      <= ST_RUN;
                            end
                        end else if (w_xfer_ok) begin
                            // A request landing on the wrap finishes this period on the
                            // old ratio and starts the very next period on the new one.
                            if (w_last) begin
                                r_div_active <= cfg.cfg_div;
                            end else begin
                                r_div_pend <= cfg.cfg_div;
                                r_state    <= ST_PEND;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef DDS_RATE_SAMPLE_CNT_EN
    logic [31:0] r_sample_cnt;

    // Advances on the same edge that raises tick, so the count and strobe line up.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_cnt <= '0;
        end else if (r_state == ST_IDLE && enable) begin
            r_sample_cnt <= '0;
        end else if (r_state != ST_IDLE && enable && w_last) begin
            r_sample_cnt <= r_sample_cnt + 32'd1;
        end
    end

    assign sample_cnt = r_sample_cnt;
`endif

    assign tick          = r_tick;
    assign clk_div       = r_clk_div;
    assign div_active    = r_div_active;
    assign busy          = (r_state != ST_IDLE);
    assign cfg.cfg_ready = (r_state != ST_PEND);
    assign cfg.cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_dds_rate_controller.sv
// tb/tb_dds_rate_controller.sv - directed self-checking bench for dds_rate_controller

module tb_dds_rate_controller;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        tick;
    logic        clk_div;
    logic [15:0] div_active;
    logic        busy;
`ifdef DDS_RATE_SAMPLE_CNT_EN
    logic [31:0] sample_cnt;
`endif

    int checks = 0;
    int errors = 0;

    dds_rate_controller_if #(.CNT_W(16)) cfg_if ();

    dds_rate_controller #(
        .CNT_W(16),
        .DIV_DEFAULT(100),
        .DIV_MIN(2)
    ) dut (
        .clk_100MHz (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cfg        (cfg_if.slave),
        .tick       (tick),
        .clk_div    (clk_div),
        .div_active (div_active),
        .busy       (busy)
`ifdef DDS_RATE_SAMPLE_CNT_EN
        ,
        .sample_cnt (sample_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Steps until tick is seen; n is the number of edges taken. Bounded by max.
    task automatic wait_tick(input string tag, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < max);
        checks++;
        assert (tick === 1'b1) else begin
            errors++;
            $error("FAIL %s_timeout: observed no tick after %0d cycles expected tick", tag, n);
        end
    endtask

    int         n;
    int         his;
    int         first_hi;
    int         tk_at;
    int         ntk;
    logic [6:0] cd;
    logic [6:0] tk;

    initial begin
        rst_n            = 1'b0;
        enable           = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
        step();
        step();

        // Reset values
        chk("rst_tick",       32'(tick),       0);
        chk("rst_clk_div",    32'(clk_div),    0);
        chk("rst_div_active", 32'(div_active), 100);
        chk("rst_busy",       32'(busy),       0);
        chk("rst_cfg_ready",  32'(cfg_if.cfg_ready), 1);
        chk("rst_cfg_err",    32'(cfg_if.cfg_err),   0);
`ifdef DDS_RATE_SAMPLE_CNT_EN
        chk("rst_sample_cnt", sample_cnt, 0);
`endif
        rst_n = 1'b1;
        step();

        // 1: default ratio, first tick on cycle 101, 50 low / 50 high
        enable = 1'b1;
        wait_tick("t1_first", 300, n);
        chk("t1_first_tick", 32'(n), 101);
        chk("t1_busy", 32'(busy), 1);
        his = 0; first_hi = 0; tk_at = 0; ntk = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (clk_div) his++;
            if (clk_div && first_hi == 0) first_hi = k;
            if (tick) begin tk_at = k; ntk++; end
        end
        chk("t1_high_cycles", 32'(his), 50);
        chk("t1_first_high", 32'(first_hi), 51);
        chk("t1_tick_pos", 32'(tk_at), 100);
        chk("t1_tick_count", 32'(ntk), 1);

        // 2: request ratio 10 at counter 37
        for (int k = 0; k < 37; k++) step();
        cfg_if.cfg_div   = 16'd10;
        cfg_if.cfg_valid = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        chk("t2_ready_pend", 32'(cfg_if.cfg_ready), 0);
        chk("t2_div_old", 32'(div_active), 100);
        wait_tick("t2_wrap", 200, n);
        chk("t2_gap_old", 32'(38 + n), 100);
        chk("t2_div_new", 32'(div_active), 10);
        chk("t2_ready_back", 32'(cfg_if.cfg_ready), 1);
        wait_tick("t2_p1", 50, n);
        chk("t2_gap_new1", 32'(n), 10);
        wait_tick("t2_p2", 50, n);
        chk("t2_gap_new2", 32'(n), 10);

        // 3: illegal ratio 1
        cfg_if.cfg_div   = 16'd1;
        cfg_if.cfg_valid = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        chk("t3_err_pulse", 32'(cfg_if.cfg_err), 1);
        step();
        chk("t3_err_clear", 32'(cfg_if.cfg_err), 0);
        chk("t3_div_kept", 32'(div_active), 10);
        chk("t3_ready", 32'(cfg_if.cfg_ready), 1);
        wait_tick("t3", 50, n);
        chk("t3_gap", 32'(2 + n), 10);

        // 4: odd ratio 7 -> low 3, high 4, tick on last high
        cfg_if.cfg_div   = 16'd7;
        cfg_if.cfg_valid = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        wait_tick("t4_wrap", 50, n);
        chk("t4_gap_old", 32'(1 + n), 10);
        chk("t4_div", 32'(div_active), 7);
        for (int k = 0; k < 7; k++) begin
            step();
            cd[k] = clk_div;
            tk[k] = tick;
        end
        chk("t4_clk_div_pattern", 32'(cd), 32'h78);
        chk("t4_tick_pattern", 32'(tk), 32'h40);

        // 5: disable while pending ratio 20
        cfg_if.cfg_div   = 16'd20;
        cfg_if.cfg_valid = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        step();
        step();
        chk("t5_ready_pend", 32'(cfg_if.cfg_ready), 0);
        enable = 1'b0;
        step();
        chk("t5_busy", 32'(busy), 0);
        chk("t5_tick", 32'(tick), 0);
        chk("t5_clk_div", 32'(clk_div), 0);
        chk("t5_div_commit", 32'(div_active), 20);
        chk("t5_ready_idle", 32'(cfg_if.cfg_ready), 1);
        step();
        enable = 1'b1;
        wait_tick("t5_restart", 100, n);
        chk("t5_first_tick", 32'(n), 21);

        // Minimum ratio 2, configured in IDLE
        enable = 1'b0;
        step();
        cfg_if.cfg_div   = 16'd2;
        cfg_if.cfg_valid = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        chk("min_div_idle", 32'(div_active), 2);
        enable = 1'b1;
        wait_tick("min_first", 20, n);
        chk("min_first_tick", 32'(n), 3);
        for (int k = 0; k < 4; k++) begin
            wait_tick("min_period", 20, n);
            chk("min_gap", 32'(n), 2);
        end
`ifdef DDS_RATE_SAMPLE_CNT_EN
        chk("cnt_five", sample_cnt, 5);
`endif
        enable = 1'b0;
        step();
`ifdef DDS_RATE_SAMPLE_CNT_EN
        chk("cnt_hold_idle", sample_cnt, 5);
`endif
        enable = 1'b1;
        step();
`ifdef DDS_RATE_SAMPLE_CNT_EN
        chk("cnt_clear_run", sample_cnt, 0);
`endif

        // 6: asynchronous reset mid-period with ratio 80
        enable = 1'b0;
        step();
        cfg_if.cfg_div   = 16'd80;
        cfg_if.cfg_valid = 1'b1;
        step();
        cfg_if.cfg_valid = 1'b0;
        chk("t6_div_80", 32'(div_active), 80);
        enable = 1'b1;
        for (int k = 0; k < 56; k++) step();
        chk("t6_pre_clk_div", 32'(clk_div), 1);
        chk("t6_pre_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #2;
        chk("t6_tick", 32'(tick), 0);
        chk("t6_clk_div", 32'(clk_div), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_div_default", 32'(div_active), 100);
        chk("t6_cfg_ready", 32'(cfg_if.cfg_ready), 1);
        chk("t6_cfg_err", 32'(cfg_if.cfg_err), 0);
`ifdef DDS_RATE_SAMPLE_CNT_EN
        chk("t6_sample_cnt", sample_cnt, 0);
`endif
        step();
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
